rtc_bus_arbiter: RTL and testbench

- Shares the single RTC register-access port between three requesters: 0 = time/date set machine, 1 = stopwatch/alarm machine, 2 = periodic display refresh reader.
- Arbitrates round-robin and issues one read or write at a time to the RTC protocol engine.
- Holds the address and data stable for the whole transaction, then returns an ack, read data and a timeout flag to the winner.
- Replaces the per-machine direct drive of address/data_mod, so no two machines ever drive the bus together.

---
 rtl/rtc_pkg.sv | 39 +++
 rtl/rr_picker.sv | 41 ++++
 rtl/rtc_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
`default_nettype none
//==============================================================================
// Module   : rtc_pkg
// Brief    : Shared types and constants for the RTC register-port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package rtc_pkg;

   localparam int NREQ = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_DONE    = 3'd3,
      ST_RELEASE = 3'd4
   } arb_state_t;

   localparam logic [7:0] c_ADDR_CONTROL = 8'h00;
   localparam logic [7:0] c_ADDR_HOURS   = 8'h21;
   localparam logic [7:0] c_ADDR_SECONDS = 8'h42;
   localparam logic [7:0] c_ADDR_MINUTES = 8'h43;

   // Width of a counter that has to reach limit-1; never narrower than 1 bit.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

   function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
//==============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick of three requesters from a pointer.
// Revision : 1.0 - initial release
//==============================================================================
module rr_picker
   import rtc_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      pointer,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   // Search upward from the pointer, wrapping past requester 2 back to 0.
   always_comb begin
      winner = '0;
      case (pointer)
         2'd1: begin
            if      (req[1]) winner = 3'b010;
            else if (req[2]) winner = 3'b100;
            else if (req[0]) winner = 3'b001;
         end
         2'd2: begin
            if      (req[2]) winner = 3'b100;
            else if (req[0]) winner = 3'b001;
            else if (req[1]) winner = 3'b010;
         end
         default: begin
            if      (req[0]) winner = 3'b001;
            else if (req[1]) winner = 3'b010;
            else if (req[2]) winner = 3'b100;
         end
      endcase
   end

   assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : rtc_bus_arbiter
// Brief    : Round-robin owner of the single RTC register port; one read or
//            write at a time with timeout and post-transaction guard gap.
// Revision : 1.0 - initial release
//==============================================================================
module rtc_bus_arbiter
   import rtc_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int GUARD   = 2
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   we,
   input  logic [8*NREQ-1:0] addr_in,
   input  logic [8*NREQ-1:0] wdata_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic              err,
   output logic [7:0]        rdata,
   output logic              rtc_start,
   output logic              rtc_we,
   output logic [7:0]        rtc_addr,
   output logic [7:0]        rtc_wdata,
   input  logic [7:0]        rtc_rdata,
   input  logic              rtc_done,
   output logic              busy
);

   localparam int c_CNT_W = cnt_width(TIMEOUT);
   localparam int c_GRD_W = cnt_width(GUARD);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
   localparam logic [c_GRD_W-1:0] c_GRD_LAST = c_GRD_W'(GUARD - 1);

   arb_state_t          r_state, w_state_nxt;
   logic [1:0]          r_ptr, w_ptr_nxt;
   logic [1:0]          r_win, w_win_nxt;
   logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [c_GRD_W-1:0]  r_grd, w_grd_nxt;
   logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
   logic [NREQ-1:0]     r_ack, w_ack_nxt;
   logic                r_err, w_err_nxt;
   logic [7:0]          r_rdata, w_rdata_nxt;
   logic                r_start, w_start_nxt;
   logic                r_we, w_we_nxt;
   logic [7:0]          r_addr, w_addr_nxt;
   logic [7:0]          r_wdata, w_wdata_nxt;
   logic                r_busy, w_busy_nxt;

   logic [NREQ-1:0]     w_pick;
   logic                w_pick_valid;
   logic [1:0]          w_pick_idx;

   rr_picker u_picker (
      .req     (req),
      .pointer (r_ptr),
      .winner  (w_pick),
      .valid   (w_pick_valid)
   );

   assign w_pick_idx = onehot_to_idx(w_pick);
   assign w_cnt_inc  = r_cnt + c_CNT_W'(1);

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_cnt   <= '0;
         r_grd   <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_start <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_win   <= w_win_nxt;
         r_cnt   <= w_cnt_nxt;
         r_grd   <= w_grd_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
         r_start <= w_start_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Every output is computed one cycle ahead here and registered above.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_win_nxt   = r_win;
      w_cnt_nxt   = r_cnt;
      w_grd_nxt   = r_grd;
      w_gnt_nxt   = r_gnt;
      w_ack_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = r_rdata;
      w_start_nxt = 1'b0;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;

      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt = ST_ISSUE;
               w_gnt_nxt   = w_pick;
               w_win_nxt   = w_pick_idx;
               w_we_nxt    = we[w_pick_idx];
               w_addr_nxt  = addr_in[{w_pick_idx, 3'b000} +: 8];
               w_wdata_nxt = wdata_in[{w_pick_idx, 3'b000} +: 8];
               w_start_nxt = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
         end
         ST_WAIT: begin
            w_cnt_nxt = w_cnt_inc;
            // Completion has priority over a timeout expiring in the same cycle.
            if (rtc_done) begin
               w_state_nxt = ST_DONE;
               w_ack_nxt   = r_gnt;
               if (!r_we) w_rdata_nxt = rtc_rdata;
            end else if (w_cnt_inc == c_CNT_LAST) begin
               w_state_nxt = ST_DONE;
               w_ack_nxt   = r_gnt;
               w_err_nxt   = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_RELEASE;
            w_gnt_nxt   = '0;
            w_grd_nxt   = '0;
            w_ptr_nxt   = (r_win == 2'(NREQ - 1)) ? 2'd0 : r_win + 2'd1;
         end
         ST_RELEASE: begin
            if (r_grd == c_GRD_LAST) w_state_nxt = ST_IDLE;
            else                     w_grd_nxt   = r_grd + c_GRD_W'(1);
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   assign gnt       = r_gnt;
   assign ack       = r_ack;
   assign err       = r_err;
   assign rdata     = r_rdata;
   assign rtc_start = r_start;
   assign rtc_we    = r_we;
   assign rtc_addr  = r_addr;
   assign rtc_wdata = r_wdata;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_rtc_bus_arbiter
// Brief    : Self-checking bench for rtc_bus_arbiter against a transaction model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_rtc_bus_arbiter;
   import rtc_pkg::*;

   localparam int TIMEOUT = 64;
   localparam int GUARD   = 2;

   logic        clk = 1'b0;
   logic        Reset_n;
   logic [2:0]  req, we, gnt, ack;
   logic [23:0] addr_in, wdata_in;
   logic        err, rtc_start, rtc_we, rtc_done, busy;
   logic [7:0]  rdata, rtc_addr, rtc_wdata, rtc_rdata;

   int total = 0;
   int bad   = 0;

   // Reference model: round-robin pointer and last read value.
   int         m_ptr;
   logic [7:0] m_rdata;

   always #5 clk = ~clk;

   rtc_bus_arbiter #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .req       (req),
      .we        (we),
      .addr_in   (addr_in),
      .wdata_in  (wdata_in),
      .gnt       (gnt),
      .ack       (ack),
      .err       (err),
      .rdata     (rdata),
      .rtc_start (rtc_start),
      .rtc_we    (rtc_we),
      .rtc_addr  (rtc_addr),
      .rtc_wdata (rtc_wdata),
      .rtc_rdata (rtc_rdata),
      .rtc_done  (rtc_done),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [2:0] r);
      for (int k = 0; k < 3; k++) begin
         if (r[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
      end
      return 0;
   endfunction

   task automatic wait_start(output bit seen, output int n);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (rtc_start === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; req = '0; we = '0; addr_in = '0; wdata_in = '0;
      rtc_rdata = '0; rtc_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({gnt, ack, err, rtc_start, rtc_we, busy} !== 10'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=0", {gnt, ack, err, rtc_start, rtc_we, busy});
      end
      total++;
      if ({rtc_addr, rtc_wdata, rdata} !== 24'h0) begin
         bad++; $display("FAIL reset_data got=%h want=0", {rtc_addr, rtc_wdata, rdata});
      end
      Reset_n = 1'b1;
      tick(); tick();
      total++;
      if (busy !== 1'b0 || gnt !== 3'b000) begin
         bad++; $display("FAIL reset_idle busy=%b gnt=%b want 0/000", busy, gnt);
      end
      m_ptr = 0; m_rdata = 8'h00;
   endtask

   task automatic test_single_write();
      bit seen; int n;
      req = 3'b001; we = 3'b001;
      addr_in  = {8'hA5, 8'h5A, c_ADDR_HOURS};
      wdata_in = {8'h77, 8'h66, 8'h12};
      wait_start(seen, n);
      total++;
      if (!seen || gnt !== 3'b001 || rtc_addr !== 8'h21 || rtc_wdata !== 8'h12 || rtc_we !== 1'b1) begin
         bad++; $display("FAIL single_issue seen=%0d gnt=%b addr=%h wdata=%h we=%b want 1/001/21/12/1",
                         seen, gnt, rtc_addr, rtc_wdata, rtc_we);
      end
      req = 3'b000;
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++;
         if (gnt !== 3'b001 || ack !== 3'b000 || rtc_start !== 1'b0 || rtc_addr !== 8'h21 || rtc_wdata !== 8'h12) begin
            bad++; $display("FAIL single_hold cyc=%0d gnt=%b ack=%b start=%b addr=%h wdata=%h", i, gnt, ack, rtc_start, rtc_addr, rtc_wdata);
         end
      end
      rtc_done = 1'b1; rtc_rdata = 8'hEE;
      tick();
      rtc_done = 1'b0;
      total++;
      if (ack !== 3'b001 || err !== 1'b0 || gnt !== 3'b001 || rdata !== m_rdata || rtc_addr !== 8'h21) begin
         bad++; $display("FAIL single_ack ack=%b err=%b gnt=%b rdata=%h want 001/0/001/%h", ack, err, gnt, rdata, m_rdata);
      end
      tick();
      total++;
      if (gnt !== 3'b000 || ack !== 3'b000 || busy !== 1'b1 || rtc_addr !== 8'h21 || rtc_wdata !== 8'h12) begin
         bad++; $display("FAIL single_release gnt=%b ack=%b busy=%b addr=%h", gnt, ack, busy, rtc_addr);
      end
      repeat (GUARD) tick();
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL single_guard busy=%b want 0", busy);
      end
      m_ptr = 1;
   endtask

   task automatic test_read();
      bit seen; int n; int exp;
      req = 3'b100; we = 3'b000;
      addr_in = {c_ADDR_SECONDS, 8'h00, 8'h00};
      exp = model_pick(req);
      wait_start(seen, n);
      total++;
      if (!seen || gnt !== 3'(1 << exp) || rtc_addr !== 8'h42 || rtc_we !== 1'b0) begin
         bad++; $display("FAIL read_issue gnt=%b addr=%h we=%b want %b/42/0", gnt, rtc_addr, rtc_we, 3'(1 << exp));
      end
      req = 3'b000;
      tick();
      rtc_done = 1'b1; rtc_rdata = 8'h35;
      tick();
      rtc_done = 1'b0; rtc_rdata = 8'hC3;
      total++;
      if (ack !== 3'b100 || err !== 1'b0 || rdata !== 8'h35) begin
         bad++; $display("FAIL read_ack ack=%b err=%b rdata=%h want 100/0/35", ack, err, rdata);
      end
      repeat (3) tick();
      total++;
      if (rdata !== 8'h35 || busy !== 1'b0) begin
         bad++; $display("FAIL read_hold rdata=%h busy=%b want 35/0", rdata, busy);
      end
      m_ptr = (exp + 1) % 3; m_rdata = 8'h35;
   endtask

   task automatic test_round_robin();
      bit seen; int n; int exp; int d; logic [7:0] rd; logic exp_we;
      req = 3'b111; we = 3'($urandom);
      for (int t = 0; t < 4; t++) begin
         exp = model_pick(req);
         exp_we = we[exp];
         wait_start(seen, n);
         total++;
         if (!seen || gnt !== 3'(1 << exp) || rtc_we !== exp_we) begin
            bad++; $display("FAIL rr_grant t=%0d gnt=%b we=%b want %b/%b", t, gnt, rtc_we, 3'(1 << exp), exp_we);
         end
         if (t > 0) begin
            total++;
            if (n !== GUARD + 2) begin
               bad++; $display("FAIL rr_gap t=%0d got=%0d want=%0d", t, n, GUARD + 2);
            end
         end
         d = $urandom_range(1, 5);
         rd = 8'($urandom);
         repeat (d) tick();
         rtc_done = 1'b1; rtc_rdata = rd;
         tick();
         rtc_done = 1'b0;
         if (!exp_we) m_rdata = rd;
         total++;
         if (ack !== 3'(1 << exp) || err !== 1'b0 || rdata !== m_rdata) begin
            bad++; $display("FAIL rr_ack t=%0d ack=%b err=%b rdata=%h want %b/0/%h", t, ack, err, rdata, 3'(1 << exp), m_rdata);
         end
         m_ptr = (exp + 1) % 3;
         we = 3'($urandom);
         if (t == 3) req = 3'b000;
      end
      repeat (GUARD + 1) tick();
   endtask

   task automatic test_random();
      bit seen; int n; int exp; int d; logic [7:0] rd; logic exp_we;
      for (int t = 0; t < 20; t++) begin
         req = 3'($urandom_range(1, 7)); we = 3'($urandom);
         addr_in = 24'($urandom); wdata_in = 24'($urandom);
         exp = model_pick(req);
         exp_we = we[exp];
         wait_start(seen, n);
         total++;
         if (!seen || gnt !== 3'(1 << exp) || rtc_we !== exp_we ||
             rtc_addr !== addr_in[8*exp +: 8] || rtc_wdata !== wdata_in[8*exp +: 8]) begin
            bad++; $display("FAIL rand_issue t=%0d gnt=%b we=%b addr=%h wdata=%h want %b/%b/%h/%h", t, gnt, rtc_we,
                            rtc_addr, rtc_wdata, 3'(1 << exp), exp_we, addr_in[8*exp +: 8], wdata_in[8*exp +: 8]);
         end
         if ($urandom_range(0, 1) == 1) req = 3'b000;
         d = $urandom_range(1, 12);
         rd = 8'($urandom);
         repeat (d) tick();
         rtc_done = 1'b1; rtc_rdata = rd;
         tick();
         rtc_done = 1'b0;
         if (!exp_we) m_rdata = rd;
         total++;
         if (ack !== 3'(1 << exp) || err !== 1'b0 || rdata !== m_rdata || rtc_addr !== addr_in[8*exp +: 8]) begin
            bad++; $display("FAIL rand_ack t=%0d ack=%b err=%b rdata=%h want %b/0/%h", t, ack, err, rdata, 3'(1 << exp), m_rdata);
         end
         m_ptr = (exp + 1) % 3;
         req = 3'b000;
         repeat (GUARD + 1) tick();
      end
   endtask

   task automatic test_timeout();
      bit seen; int n;
      req = 3'b010; we = 3'b000;
      addr_in = {8'h00, c_ADDR_MINUTES, 8'h00};
      rtc_rdata = 8'h99;
      wait_start(seen, n);
      total++;
      if (!seen || gnt !== 3'b010) begin
         bad++; $display("FAIL timeout_issue gnt=%b want 010", gnt);
      end
      req = 3'b000;
      n = 0;
      while (ack === 3'b000 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (n !== TIMEOUT) begin
         bad++; $display("FAIL timeout_latency got=%0d want=%0d", n, TIMEOUT);
      end
      total++;
      if (ack !== 3'b010 || err !== 1'b1 || rdata !== m_rdata) begin
         bad++; $display("FAIL timeout_ack ack=%b err=%b rdata=%h want 010/1/%h", ack, err, rdata, m_rdata);
      end
      m_ptr = 2;
      repeat (GUARD + 1) tick();
   endtask

   task automatic test_collision();
      bit seen; int n; int exp; logic [7:0] rd;
      req = 3'b001; we = 3'b000;
      addr_in = {8'h00, 8'h00, c_ADDR_CONTROL};
      exp = model_pick(req);
      wait_start(seen, n);
      req = 3'b000;
      repeat (TIMEOUT - 1) tick();
      rd = 8'($urandom);
      rtc_done = 1'b1; rtc_rdata = rd;
      tick();
      rtc_done = 1'b0;
      total++;
      if (!seen || ack !== 3'(1 << exp) || err !== 1'b0 || rdata !== rd) begin
         bad++; $display("FAIL collision_ack ack=%b err=%b rdata=%h want %b/0/%h", ack, err, rdata, 3'(1 << exp), rd);
      end
      m_rdata = rd; m_ptr = (exp + 1) % 3;
      repeat (GUARD + 1) tick();
      rtc_done = 1'b1;
      tick();
      rtc_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (busy !== 1'b0 || gnt !== 3'b000 || ack !== 3'b000 || rtc_start !== 1'b0 || rdata !== m_rdata) begin
            bad++; $display("FAIL idle_done busy=%b gnt=%b ack=%b start=%b rdata=%h", busy, gnt, ack, rtc_start, rdata);
         end
         tick();
      end
   endtask

   task automatic test_reset_midwait();
      bit seen; int n;
      req = 3'b100; we = 3'b000;
      wait_start(seen, n);
      req = 3'b000;
      tick(); tick();
      #2 Reset_n = 1'b0;
      #1;
      total++;
      if ({gnt, ack, err, rtc_start, rtc_we, busy} !== 10'b0 || {rtc_addr, rtc_wdata, rdata} !== 24'h0) begin
         bad++; $display("FAIL reset_async ctrl=%b data=%h want 0", {gnt, ack, err, rtc_start, rtc_we, busy},
                         {rtc_addr, rtc_wdata, rdata});
      end
      tick();
      Reset_n = 1'b1;
      m_ptr = 0; m_rdata = 8'h00;
      rtc_done = 1'b1; rtc_rdata = 8'h5C;
      tick();
      rtc_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ack !== 3'b000 || err !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) begin
            bad++; $display("FAIL reset_stale ack=%b err=%b busy=%b rdata=%h want 000/0/0/00", ack, err, busy, rdata);
         end
         tick();
      end
      req = 3'b111; we = 3'b111;
      wait_start(seen, n);
      total++;
      if (!seen || gnt !== 3'b001 || gnt !== 3'(1 << model_pick(3'b111))) begin
         bad++; $display("FAIL reset_ptr gnt=%b want 001", gnt);
      end
      req = 3'b000;
      tick();
      rtc_done = 1'b1;
      tick();
      rtc_done = 1'b0;
      total++;
      if (ack !== 3'b001 || err !== 1'b0) begin
         bad++; $display("FAIL reset_next_ack ack=%b err=%b want 001/0", ack, err);
      end
      repeat (GUARD + 1) tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_round_robin();
      test_random();
      test_timeout();
      test_collision();
      test_reset_midwait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
